// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding, timing defaults and elaboration helpers for the SRAM controller.
package sram_ctrl_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_RD_WAIT = 2;
  localparam int DEF_WR_WAIT = 2;
  localparam int DEF_TURN    = 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_TURN     = 3'd5
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module sram_wait_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_ctrl_sync.sv
// Single-beat async SRAM controller: sequences CE/OE/WE with wait states and bus turnaround.
// Every pin output comes straight from a flop; read data lands in rdata one cycle before rvalid.
module sram_ctrl_sync
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_WAIT = DEF_RD_WAIT,
  parameter int WR_WAIT = DEF_WR_WAIT,
  parameter int TURN    = DEF_TURN
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              wdone,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  inout  wire  [DATA_W-1:0] sram_dq
);

  localparam int CNT_W = clog2(max3(RD_WAIT, WR_WAIT, TURN) + 1);
  localparam logic [CNT_W-1:0] RD_LD   = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LD   = CNT_W'(WR_WAIT - 1);
  localparam logic [CNT_W-1:0] TURN_LD = CNT_W'((TURN > 0) ? TURN - 1 : 0);
  localparam state_t POST_ST = (TURN > 0) ? ST_TURN : ST_IDLE;

  state_t            state;
  logic              dq_oe;
  logic [DATA_W-1:0] dq_out;
  logic              rd_pend;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_dec;
  logic              cnt_zero;

  sram_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Counter is preloaded one state ahead so the owning state sees the full N cycles.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    unique case (state)
      ST_IDLE:     begin cnt_load = 1'b1; cnt_val = RD_LD; end
      ST_RD:       begin cnt_load = cnt_zero; cnt_val = TURN_LD; cnt_dec = !cnt_zero; end
      ST_WR_SETUP: begin cnt_load = 1'b1; cnt_val = WR_LD; end
      ST_WR_PULSE: cnt_dec = 1'b1;
      ST_WR_HOLD:  begin cnt_load = 1'b1; cnt_val = TURN_LD; end
      ST_TURN:     cnt_dec = 1'b1;
      default:     cnt_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      ready     <= 1'b1;
      rdata     <= '0;
      rvalid    <= 1'b0;
      rd_pend   <= 1'b0;
      wdone     <= 1'b0;
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else begin
      rvalid  <= rd_pend;
      rd_pend <= 1'b0;
      wdone   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            ready     <= 1'b0;
            sram_addr <= addr;
            sram_ce_n <= 1'b0;
            if (we) begin
              dq_out <= wdata;
              dq_oe  <= 1'b1;
              state  <= ST_WR_SETUP;
            end else begin
              sram_oe_n <= 1'b0;
              state     <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (cnt_zero) begin
            rdata     <= sram_dq;
            rd_pend   <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            state     <= POST_ST;
            ready     <= (TURN == 0);
          end
        end
        ST_WR_SETUP: begin
          sram_we_n <= 1'b0;
          state     <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          if (cnt_zero) begin
            sram_we_n <= 1'b1;
            state     <= ST_WR_HOLD;
          end
        end
        ST_WR_HOLD: begin
          wdone     <= 1'b1;
          sram_ce_n <= 1'b1;
          dq_oe     <= 1'b0;
          state     <= POST_ST;
          ready     <= (TURN == 0);
        end
        ST_TURN: begin
          if (cnt_zero) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign sram_dq = dq_oe ? dq_out : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl_sync.sv
// Directed bench: default-parameter controller plus a wide/short-timing variant, each with an SRAM model.
module tb_sram_ctrl_sync;

  localparam logic [7:0]  KEEP1 = 8'h5A;
  localparam logic [15:0] KEEP2 = 16'h5A5A;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  // DUT1: defaults (16/8, RD_WAIT=2, WR_WAIT=2, TURN=1)
  logic        req1, we1, ready1, rvalid1, wdone1, ce1_n, oe1_n, we1_n;
  logic [15:0] addr1, a1;
  logic [7:0]  wdata1, rdata1;
  wire  [7:0]  dq1;
  logic [15:0] m1_addr = 16'h0;
  logic [7:0]  m1_data = 8'h0;

  // DUT2: 19/16, RD_WAIT=1, WR_WAIT=3, TURN=0
  logic        req2, we2, ready2, rvalid2, wdone2, ce2_n, oe2_n, we2_n;
  logic [18:0] addr2, a2;
  logic [15:0] wdata2, rdata2;
  wire  [15:0] dq2;
  logic [18:0] m2_addr = 19'h0;
  logic [15:0] m2_data = 16'h0;

  sram_ctrl_sync #(.ADDR_W(16), .DATA_W(8), .RD_WAIT(2), .WR_WAIT(2), .TURN(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .ready(ready1), .rdata(rdata1), .rvalid(rvalid1), .wdone(wdone1),
    .sram_addr(a1), .sram_ce_n(ce1_n), .sram_oe_n(oe1_n), .sram_we_n(we1_n), .sram_dq(dq1)
  );

  sram_ctrl_sync #(.ADDR_W(19), .DATA_W(16), .RD_WAIT(1), .WR_WAIT(3), .TURN(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .ready(ready2), .rdata(rdata2), .rvalid(rvalid2), .wdone(wdone2),
    .sram_addr(a2), .sram_ce_n(ce2_n), .sram_oe_n(oe2_n), .sram_we_n(we2_n), .sram_dq(dq2)
  );

  // Board keeper drives a known pattern while the chip is deselected; the SRAM drives on CE&OE.
  assign dq1 = ce1_n ? KEEP1 : (!oe1_n ? ((a1 == m1_addr) ? m1_data : 8'h00) : 8'hzz);
  assign dq2 = ce2_n ? KEEP2 : (!oe2_n ? ((a2 == m2_addr) ? m2_data : 16'h0000) : 16'hzzzz);

  always @(negedge clk) begin
    if (!ce1_n && !we1_n) begin m1_addr <= a1; m1_data <= dq1; end
    if (!ce2_n && !we2_n) begin m2_addr <= a2; m2_data <= dq2; end
    if ((!oe1_n && !we1_n) || (!oe2_n && !we2_n)) overlap <= overlap + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int cyc, gap, rdy_cnt, wd_cnt, rv_cnt;
    logic found, in_gap;
    logic [7:0] got;

    reset_n = 1'b0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    req2 = 0; we2 = 0; addr2 = '0; wdata2 = '0;
    tick(); tick();

    chk("rst_ready", ready1, 1);
    chk("rst_rvalid", rvalid1, 0);
    chk("rst_wdone", wdone1, 0);
    chk("rst_rdata", rdata1, 0);
    chk("rst_strobes", {ce1_n, oe1_n, we1_n}, 3'b111);
    chk("rst_addr", a1, 0);
    chk("rst_dq", dq1, KEEP1);

    // Reset landing in the middle of a write pulse
    reset_n = 1'b1;
    tick();
    req1 = 1; we1 = 1; addr1 = 16'h0F0F; wdata1 = 8'h11;
    tick();
    req1 = 0;
    tick();
    chk("t1_we_low", we1_n, 0);
    reset_n = 1'b0;
    tick();
    chk("t1_we_n", we1_n, 1);
    chk("t1_ce_n", ce1_n, 1);
    chk("t1_dq", dq1, KEEP1);
    chk("t1_ready", ready1, 1);
    chk("t1_wdone", wdone1, 0);
    reset_n = 1'b1;
    wd_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wdone1) wd_cnt++;
    end
    chk("t1_no_wdone", wd_cnt, 0);

    // Write 1234 <- A5
    req1 = 1; we1 = 1; addr1 = 16'h1234; wdata1 = 8'hA5;
    tick();
    req1 = 0;
    chk("t2_e0_ctrl", {ready1, ce1_n, oe1_n, we1_n}, 4'b0011);
    chk("t2_e0_dq", dq1, 8'hA5);
    chk("t2_e0_addr", a1, 16'h1234);
    tick();
    chk("t2_e1_we", we1_n, 0);
    chk("t2_e1_dq", dq1, 8'hA5);
    tick();
    chk("t2_e2_we", we1_n, 0);
    tick();
    chk("t2_e3_hold", {ce1_n, we1_n, wdone1}, 3'b010);
    chk("t2_e3_dq", dq1, 8'hA5);
    tick();
    chk("t2_e4_wdone", wdone1, 1);
    chk("t2_e4_ce", ce1_n, 1);
    chk("t2_e4_dq", dq1, KEEP1);
    chk("t2_e4_addr", a1, 16'h1234);
    chk("t2_e4_ready", ready1, 0);
    tick();
    chk("t2_e5", {wdone1, ready1}, 2'b01);

    // Read 1234 -> A5
    req1 = 1; we1 = 0; addr1 = 16'h1234;
    tick();
    req1 = 0;
    chk("t3_e0", {ce1_n, oe1_n, we1_n, rvalid1}, 4'b0010);
    tick();
    chk("t3_e1_oe", oe1_n, 0);
    tick();
    chk("t3_e2", {oe1_n, rvalid1}, 2'b10);
    tick();
    chk("t3_e3_rvalid", rvalid1, 1);
    chk("t3_e3_rdata", rdata1, 8'hA5);
    tick();
    chk("t3_e4_rvalid", rvalid1, 0);

    // Write then read with req held throughout; busy requests must be ignored
    req1 = 1; we1 = 1; addr1 = 16'h0042; wdata1 = 8'h3C;
    tick();
    we1 = 0;
    cyc = 0; gap = 0; rdy_cnt = 0; wd_cnt = 0; found = 0; in_gap = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      cyc++;
      if (wdone1) begin wd_cnt++; in_gap = 1; end
      if (ready1) rdy_cnt++;
      if (!oe1_n) found = 1;
      else if (in_gap && ce1_n && oe1_n && we1_n && (dq1 === KEEP1)) gap++;
    end
    req1 = 0;
    chk("t4_oe_seen", found, 1);
    chk("t4_oe_cycle", cyc, 6);
    chk("t4_turn_gap", gap, 2);
    chk("t5_one_write", wd_cnt, 1);
    chk("t5_ready_cycles", rdy_cnt, 1);
    rv_cnt = 0; got = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rvalid1) begin rv_cnt++; got = rdata1; end
    end
    chk("t5_one_read", rv_cnt, 1);
    chk("t4_rdata", got, 8'h3C);
    chk("t5_ready_end", ready1, 1);

    // Wide variant: write 7FFFF <- BEEF, read back
    req2 = 1; we2 = 1; addr2 = 19'h7FFFF; wdata2 = 16'hBEEF;
    tick();
    req2 = 0;
    chk("t6_e0_ctrl", {ce2_n, we2_n}, 2'b01);
    chk("t6_e0_dq", dq2, 16'hBEEF);
    chk("t6_e0_addr", a2, 19'h7FFFF);
    tick();
    chk("t6_e1_we", we2_n, 0);
    tick();
    tick();
    chk("t6_e3_we", we2_n, 0);
    tick();
    chk("t6_e4_hold", {we2_n, wdone2}, 2'b10);
    tick();
    chk("t6_e5", {wdone2, ready2}, 2'b11);
    req2 = 1; we2 = 0; addr2 = 19'h7FFFF;
    tick();
    req2 = 0;
    chk("t6_rd_oe", oe2_n, 0);
    tick();
    chk("t6_rd_e1", {oe2_n, rvalid2, ready2}, 3'b101);
    tick();
    chk("t6_rvalid", rvalid2, 1);
    chk("t6_rdata", rdata2, 16'hBEEF);

    chk("no_oe_we_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
